// File: rtl/reflet_pkg.sv
// rtl/reflet_pkg.sv - shared opcodes, register indices, SR bits and FSM states for the Reflet core
package reflet_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEMWAIT,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_SYS  = 4'h0;
  localparam logic [3:0] OP_SET  = 4'h1;
  localparam logic [3:0] OP_READ = 4'h2;
  localparam logic [3:0] OP_CPY  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LSL  = 4'hA;
  localparam logic [3:0] OP_LSR  = 4'hB;
  localparam logic [3:0] OP_EQ   = 4'hC;
  localparam logic [3:0] OP_LES  = 4'hD;
  localparam logic [3:0] OP_STR  = 4'hE;
  localparam logic [3:0] OP_LOAD = 4'hF;

  // Low nibble of the OP_SYS group selects the system instruction
  localparam logic [3:0] SYS_NOP    = 4'h0;
  localparam logic [3:0] SYS_JIF    = 4'h1;
  localparam logic [3:0] SYS_CALL   = 4'h2;
  localparam logic [3:0] SYS_RET    = 4'h3;
  localparam logic [3:0] SYS_PUSH   = 4'h4;
  localparam logic [3:0] SYS_POP    = 4'h5;
  localparam logic [3:0] SYS_RETINT = 4'h6;
  localparam logic [3:0] SYS_QUIT   = 4'h7;
  localparam logic [3:0] SYS_DEBUG  = 4'h8;

  localparam logic [3:0] R_WR  = 4'd0;
  localparam logic [3:0] R_SR  = 4'd12;
  localparam logic [3:0] R_SP  = 4'd13;
  localparam logic [3:0] R_PC  = 4'd14;
  localparam logic [3:0] R_IRA = 4'd15;

  localparam int SR_CMP     = 0;
  localparam int SR_INT     = 1;
  localparam int SR_MASK_LO = 4;

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] k;
    k = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) k = 2'(i);
    end
    return k;
  endfunction

endpackage

// File: rtl/reflet_alu.sv
// rtl/reflet_alu.sv - combinational arithmetic/logic/shift unit and comparison flag
module reflet_alu
  import reflet_pkg::*;
#(
  parameter int wordsize = 8
) (
  input  logic [3:0]          op,
  input  logic [wordsize-1:0] a,
  input  logic [wordsize-1:0] b,
  output logic [wordsize-1:0] result,
  output logic                cmp
);

  localparam logic [wordsize-1:0] shift_limit = wordsize'(wordsize);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~b;
      OP_LSL:  result = (b >= shift_limit) ? '0 : (a << b);
      OP_LSR:  result = (b >= shift_limit) ? '0 : (a >> b);
      default: result = '0;
    endcase
  end

  always_comb begin
    cmp = 1'b0;
    if (op == OP_EQ) cmp = (a == b);
    else if (op == OP_LES) cmp = (a < b);
  end

endmodule

// File: rtl/reflet_cpu.sv
// rtl/reflet_cpu.sv - multi-cycle Reflet accumulator core with one synchronous memory port
// and four rising-edge interrupts vectored to 4*(k+1).
module reflet_cpu
  import reflet_pkg::*;
#(
  parameter int wordsize = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic                quit,
  output logic                debug,
  input  logic [wordsize-1:0] data_in,
  output logic [wordsize-1:0] addr,
  output logic [wordsize-1:0] data_out,
  output logic                write_en,
  input  logic [3:0]          ext_int
);

  localparam logic [wordsize-1:0] one = wordsize'(1);

  state_t state, state_next;
  logic [wordsize-1:0] regs [16];
  logic [7:0] ir;
  logic [3:0] ext_prev, pend, rise, clear;
  logic [3:0] opcode, n;
  logic [wordsize-1:0] wr, sr, sp, pc, ira, rn;
  logic [wordsize-1:0] alu_result;
  logic alu_cmp;
  logic [3:0] int_ready;
  logic int_take;
  logic [1:0] int_k;
  logic [4:0] int_vec;

  assign opcode = ir[7:4];
  assign n      = ir[3:0];
  assign wr     = regs[R_WR];
  assign sr     = regs[R_SR];
  assign sp     = regs[R_SP];
  assign pc     = regs[R_PC];
  assign ira    = regs[R_IRA];
  assign rn     = regs[n];

  assign int_ready = pend & sr[SR_MASK_LO +: 4];
  assign int_take  = (state == S_FETCH) && !sr[SR_INT] && (|int_ready);
  assign int_k     = lowest_set(int_ready);
  assign int_vec   = {3'(int_k) + 3'd1, 2'b00};

  // Edge capture runs regardless of enable; a new edge wins over the clear of its own bit
  assign rise  = ext_int & ~ext_prev;
  assign clear = (enable && int_take) ? (4'b0001 << int_k) : 4'b0000;

  reflet_alu #(.wordsize(wordsize)) u_alu (
    .op    (opcode),
    .a     (wr),
    .b     (rn),
    .result(alu_result),
    .cmp   (alu_cmp)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else if (enable) state <= state_next;
  end

  always_comb begin
    state_next = state;
    addr       = pc;
    data_out   = '0;
    write_en   = 1'b0;
    debug      = 1'b0;
    case (state)
      S_FETCH: begin
        if (!int_take) state_next = S_DECODE;
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        state_next = S_FETCH;
        case (opcode)
          OP_STR: begin
            addr     = rn;
            data_out = wr;
            write_en = 1'b1;
          end
          OP_LOAD: begin
            addr       = rn;
            state_next = S_MEMWAIT;
          end
          OP_SYS: begin
            case (n)
              SYS_CALL: begin
                addr     = sp - one;
                data_out = pc;
                write_en = 1'b1;
              end
              SYS_PUSH: begin
                addr     = sp - one;
                data_out = wr;
                write_en = 1'b1;
              end
              SYS_RET, SYS_POP: begin
                addr       = sp;
                state_next = S_MEMWAIT;
              end
              SYS_QUIT:  state_next = S_HALT;
              SYS_DEBUG: debug = 1'b1;
              default:   state_next = S_FETCH;
            endcase
          end
          default: state_next = S_FETCH;
        endcase
      end
      // Address stays on the operand so read data is stable even while frozen
      S_MEMWAIT: begin
        addr       = (opcode == OP_LOAD) ? rn : sp;
        state_next = S_FETCH;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      ir       <= '0;
      ext_prev <= '0;
      pend     <= '0;
      quit     <= 1'b0;
    end else begin
      ext_prev <= ext_int;
      pend     <= (pend & ~clear) | rise;
      if (enable) begin
        case (state)
          S_FETCH: begin
            if (int_take) begin
              regs[R_IRA]         <= pc;
              regs[R_PC]          <= wordsize'(int_vec);
              regs[R_SR][SR_INT]  <= 1'b1;
            end
          end
          S_DECODE: begin
            ir         <= data_in[7:0];
            regs[R_PC] <= pc + one;
          end
          S_EXEC: begin
            case (opcode)
              OP_SET:  regs[R_WR] <= wordsize'(n);
              OP_READ: regs[R_WR] <= rn;
              OP_CPY:  regs[n] <= wr;
              OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LSL, OP_LSR:
                regs[R_WR] <= alu_result;
              OP_EQ, OP_LES: regs[R_SR][SR_CMP] <= alu_cmp;
              OP_SYS: begin
                case (n)
                  SYS_NOP: ;
                  SYS_JIF: if (sr[SR_CMP]) regs[R_PC] <= wr;
                  SYS_CALL: begin
                    regs[R_SP] <= sp - one;
                    regs[R_PC] <= wr;
                  end
                  SYS_PUSH: regs[R_SP] <= sp - one;
                  SYS_RETINT: begin
                    regs[R_PC]         <= ira;
                    regs[R_SR][SR_INT] <= 1'b0;
                  end
                  SYS_QUIT: quit <= 1'b1;
                  default: ;
                endcase
              end
              default: ;
            endcase
          end
          S_MEMWAIT: begin
            if (opcode == OP_LOAD) begin
              regs[R_WR] <= data_in;
            end else begin
              if (n == SYS_RET) regs[R_PC] <= data_in;
              else regs[R_WR] <= data_in;
              regs[R_SP] <= sp + one;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reflet_cpu.sv
// tb/tb_reflet_cpu.sv - directed self-checking bench for reflet_cpu with a synchronous 256x8 memory
module tb_reflet_cpu;
  import reflet_pkg::*;

  logic clk, reset, enable, quit, debug, write_en, load;
  logic [7:0] data_in, addr, data_out;
  logic [3:0] ext_int;
  logic [7:0] mem  [256];
  logic [7:0] prog [256];
  int n_pass, n_total;

  reflet_cpu #(.wordsize(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .quit    (quit),
    .debug   (debug),
    .data_in (data_in),
    .addr    (addr),
    .data_out(data_out),
    .write_en(write_en),
    .ext_int (ext_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= prog[i];
    end else if (write_en) begin
      mem[addr] <= data_out;
    end
    data_in <= mem[addr];
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] rg(input int i);
    return dut.regs[i];
  endfunction

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
  endtask

  task automatic put(input int base, input logic [7:0] b [$]);
    foreach (b[i]) prog[base + i] = b[i];
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; ext_int = 4'b0000; load = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    reset = 1'b0;
  endtask

  // Jumps to 0x1E, builds SR = mask_set << 4, then runs NOPs from 0x23
  task automatic int_prog(input logic [7:0] mask_set);
    clear_prog();
    put(0, '{8'h1F, 8'h31, 8'h41, 8'h3E});
    put(8'h1E, '{8'h14, 8'h32, mask_set, 8'hA2, 8'h3C});
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b1; enable = 1'b1; ext_int = 4'b0000; load = 1'b0;

    // 1: SET 5; CPY 1; SET 3; ADD 1; QUIT
    clear_prog();
    put(0, '{8'h15, 8'h31, 8'h13, 8'h41, 8'h07});
    do_reset();
    check("rst_addr", addr, 8'h00);
    check("rst_data_out", data_out, 8'h00);
    check("rst_write_en", 8'(write_en), 8'h00);
    check("rst_quit", 8'(quit), 8'h00);
    check("rst_debug", 8'(debug), 8'h00);
    check("rst_state", 8'(dut.state), 8'(S_FETCH));
    step(14);
    check("t1_quit_early", 8'(quit), 8'h00);
    step(1);
    check("t1_quit", 8'(quit), 8'h01);
    check("t1_wr", rg(0), 8'h08);
    check("t1_r1", rg(1), 8'h05);
    step(4);
    check("t1_halt_pc", rg(14), 8'h05);
    check("t1_halt_quit", 8'(quit), 8'h01);
    check("t1_halt_we", 8'(write_en), 8'h00);

    // 2: EQ true, LES false, JIF not taken
    clear_prog();
    put(0, '{8'h13, 8'h32, 8'h13, 8'hC2, 8'h14, 8'hD2, 8'h1F, 8'h01, 8'h07});
    do_reset();
    step(12);
    check("t2_eq_cmp", 8'(rg(12) & 8'h01), 8'h01);
    step(6);
    check("t2_les_cmp", 8'(rg(12) & 8'h01), 8'h00);
    step(9);
    check("t2_jif_quit", 8'(quit), 8'h01);
    check("t2_jif_pc", rg(14), 8'h09);

    // 2b: ALU operations, shift >= wordsize, STR/LOAD
    clear_prog();
    put(0, '{8'h1C, 8'h31, 8'h15, 8'h51, 8'h32, 8'h13, 8'h33, 8'h22, 8'hA3,
             8'h34, 8'hB3, 8'h35, 8'hA1, 8'h36, 8'h22, 8'h61, 8'h37, 8'h71,
             8'h82, 8'h38, 8'h94, 8'h39, 8'hE1, 8'h10, 8'hF1, 8'h07});
    do_reset();
    step(78);
    check("alu_quit_early", 8'(quit), 8'h00);
    step(1);
    check("alu_quit", 8'(quit), 8'h01);
    check("alu_sub", rg(2), 8'hF9);
    check("alu_lsl", rg(4), 8'hC8);
    check("alu_lsr", rg(5), 8'h19);
    check("alu_lsl_big", rg(6), 8'h00);
    check("alu_and", rg(7), 8'h08);
    check("alu_or_xor", rg(8), 8'hF5);
    check("alu_not", rg(9), 8'h37);
    check("alu_str_mem", mem[12], 8'h37);
    check("alu_load_wr", rg(0), 8'h37);

    // 3: single interrupt and RETINT
    int_prog(8'h11);
    put(8'h04, '{8'h06});
    do_reset();
    step(27);
    check("t3_pc_main", rg(14), 8'h23);
    check("t3_sr", rg(12), 8'h10);
    step(3);
    ext_int = 4'b0001;
    step(1);
    ext_int = 4'b0000;
    step(3);
    check("t3_vec_pc", rg(14), 8'h04);
    check("t3_ira", rg(15), 8'h25);
    check("t3_in_int", 8'(rg(12) & 8'h02), 8'h02);
    step(3);
    check("t3_ret_pc", rg(14), 8'h25);
    check("t3_ret_in_int", 8'(rg(12) & 8'h02), 8'h00);

    // 4: edge captured while frozen, taken once; masked edge stays pending
    int_prog(8'h11);
    put(8'h04, '{8'h06});
    do_reset();
    step(27);
    enable = 1'b0;
    step(1);
    ext_int = 4'b1001;
    step(1);
    ext_int = 4'b0000;
    step(3);
    check("t4_frozen_pc", rg(14), 8'h23);
    check("t4_pend", 8'(dut.pend), 8'h09);
    enable = 1'b1;
    step(1);
    check("t4_vec_pc", rg(14), 8'h04);
    check("t4_ira", rg(15), 8'h23);
    step(3);
    check("t4_ret_pc", rg(14), 8'h23);
    step(6);
    check("t4_once_pc", rg(14), 8'h25);
    check("t4_masked_pend", 8'(dut.pend), 8'h08);
    do_reset();
    check("t4_reset_pend", 8'(dut.pend), 8'h00);

    // 5: simultaneous edges on ext_int[2:1], lower index first
    int_prog(8'h16);
    put(8'h08, '{8'h06});
    put(8'h0C, '{8'h06});
    do_reset();
    step(30);
    ext_int = 4'b0110;
    step(1);
    ext_int = 4'b0000;
    step(3);
    check("t5_first_vec", rg(14), 8'h08);
    check("t5_first_ira", rg(15), 8'h25);
    step(3);
    check("t5_ret_pc", rg(14), 8'h25);
    step(1);
    check("t5_second_vec", rg(14), 8'h0C);
    check("t5_second_in_int", 8'(rg(12) & 8'h02), 8'h02);
    step(3);
    check("t5_done_pc", rg(14), 8'h25);
    check("t5_done_pend", 8'(dut.pend), 8'h00);

    // 6: CALL with SP=0, write held while frozen, DEBUG pulse, RET
    clear_prog();
    put(0, '{8'h14, 8'h31, 8'h14, 8'hA1, 8'h02, 8'h07});
    put(8'h40, '{8'h08, 8'h03});
    do_reset();
    step(14);
    check("t6_call_we", 8'(write_en), 8'h01);
    check("t6_call_addr", addr, 8'hFF);
    check("t6_call_data", data_out, 8'h05);
    enable = 1'b0;
    step(2);
    check("t6_hold_we", 8'(write_en), 8'h01);
    check("t6_hold_pc", rg(14), 8'h05);
    enable = 1'b1;
    step(1);
    check("t6_after_we", 8'(write_en), 8'h00);
    check("t6_sp", rg(13), 8'hFF);
    check("t6_pc", rg(14), 8'h40);
    check("t6_stack_mem", mem[255], 8'h05);
    step(2);
    check("t6_debug_on", 8'(debug), 8'h01);
    step(1);
    check("t6_debug_off", 8'(debug), 8'h00);
    step(4);
    check("t6_ret_pc", rg(14), 8'h05);
    check("t6_ret_sp", rg(13), 8'h00);
    step(3);
    check("t6_quit", 8'(quit), 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
